// File: rtl/rgb_pwm_fader.sv
// Multi-channel LED PWM driver. Duty changes take effect only at a period
// boundary, either as a direct jump or as an optional one-step-per-interval fade.
module rgb_pwm_fader #(
    parameter int NCH      = 3,
    parameter int DW       = 7,
    parameter int PERIOD   = 100,
    parameter int LED_W    = 4,
    parameter int FADE_DIV = 1
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    input  logic [NCH*DW-1:0]    LEVEL_IN,
    input  logic                 LOAD,
    input  logic                 FADE_EN,
    output logic [NCH*LED_W-1:0] LED_OUT,
    output logic                 PERIOD_TICK,
    output logic                 BUSY
);

    localparam int CW = $clog2(PERIOD);
    localparam int FW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    // Duty registers carry one extra bit so that a full-on level of PERIOD = 2^DW fits.
    localparam int AW = DW + 1;

    logic [CW-1:0] cnt;
    logic [FW-1:0] fdiv;
    logic [FW-1:0] fdiv_nxt;
    logic [AW-1:0] tgt     [NCH];
    logic [AW-1:0] act     [NCH];
    logic [AW-1:0] tgt_nxt [NCH];
    logic [AW-1:0] act_nxt [NCH];
    logic [AW-1:0] lvl     [NCH];
    logic          boundary;
    logic          fade_step;
    logic          busy_nxt;

    for (genvar g = 0; g < NCH; g++) begin : g_lvl
        assign lvl[g] = {1'b0, LEVEL_IN[g*DW +: DW]};
    end

    assign boundary  = (cnt == CW'(PERIOD - 1));
    assign fade_step = FADE_EN && (fdiv == FW'(FADE_DIV - 1));

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            tgt_nxt[i] = tgt[i];
            if (LOAD) begin
                tgt_nxt[i] = (lvl[i] > AW'(PERIOD)) ? AW'(PERIOD) : lvl[i];
            end
        end
    end

    // The boundary update deliberately reads the pre-edge target, so a LOAD
    // landing on the boundary cycle is only acted on one period later.
    always_comb begin
        fdiv_nxt = fdiv;
        for (int i = 0; i < NCH; i++) begin
            act_nxt[i] = act[i];
        end
        if (boundary) begin
            if (!FADE_EN) begin
                fdiv_nxt = '0;
                for (int i = 0; i < NCH; i++) begin
                    act_nxt[i] = tgt[i];
                end
            end else if (fade_step) begin
                fdiv_nxt = '0;
                for (int i = 0; i < NCH; i++) begin
                    if (act[i] < tgt[i]) begin
                        act_nxt[i] = act[i] + AW'(1);
                    end else if (act[i] > tgt[i]) begin
                        act_nxt[i] = act[i] - AW'(1);
                    end
                end
            end else begin
                fdiv_nxt = fdiv + FW'(1);
            end
        end
    end

    always_comb begin
        busy_nxt = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (act_nxt[i] != tgt_nxt[i]) begin
                busy_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            cnt         <= '0;
            fdiv        <= '0;
            PERIOD_TICK <= 1'b0;
            BUSY        <= 1'b0;
            LED_OUT     <= '0;
            for (int i = 0; i < NCH; i++) begin
                tgt[i] <= '0;
                act[i] <= '0;
            end
        end else begin
            cnt         <= boundary ? '0 : cnt + CW'(1);
            fdiv        <= fdiv_nxt;
            PERIOD_TICK <= boundary;
            BUSY        <= busy_nxt;
            for (int i = 0; i < NCH; i++) begin
                tgt[i] <= tgt_nxt[i];
                act[i] <= act_nxt[i];
                LED_OUT[i*LED_W +: LED_W] <= {LED_W{AW'(cnt) < act[i]}};
            end
        end
    end

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Bench for rgb_pwm_fader: directed scenarios plus random traffic, checked
// cycle by cycle against an integer reference model and per-period high counts.
module tb_rgb_pwm_fader;

    localparam int NCH = 3;
    localparam int DW  = 7;
    localparam int P   = 100;
    localparam int LW  = 4;
    localparam int FD  = 2;

    logic                clk = 1'b0;
    logic                rstn;
    logic [NCH*DW-1:0]   level;
    logic                load;
    logic                fade_en;
    logic [NCH*LW-1:0]   led_out;
    logic                period_tick;
    logic                busy;

    int n_checks = 0;
    int n_errors = 0;

    int m_cnt, m_fdiv, m_tick, m_busy;
    int m_tgt [NCH];
    int m_act [NCH];
    int m_led [NCH];
    int hi_cnt [NCH];
    int per_act [NCH];
    int pc_valid;
    logic [NCH*LW-1:0] exp_led;

    rgb_pwm_fader #(
        .NCH(NCH), .DW(DW), .PERIOD(P), .LED_W(LW), .FADE_DIV(FD)
    ) dut (
        .CLK(clk),
        .RESETN(rstn),
        .LEVEL_IN(level),
        .LOAD(load),
        .FADE_EN(fade_en),
        .LED_OUT(led_out),
        .PERIOD_TICK(period_tick),
        .BUSY(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, obs, exp);
        end
    endtask

    // Reference model: integer state following the behavioural rules, plus a
    // per-period count of high cycles that must equal the duty of that period.
    always @(posedge clk) begin
        if (!rstn) begin
            m_cnt = 0; m_fdiv = 0; m_tick = 0; m_busy = 0; pc_valid = 0;
            for (int i = 0; i < NCH; i++) begin
                m_tgt[i] = 0; m_act[i] = 0; m_led[i] = 0; hi_cnt[i] = 0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) m_led[i] = (m_cnt < m_act[i]) ? 1 : 0;
            m_tick = (m_cnt == P - 1) ? 1 : 0;
            if (m_tick == 1) begin
                if (!fade_en) begin
                    m_fdiv = 0;
                    for (int i = 0; i < NCH; i++) m_act[i] = m_tgt[i];
                end else if (m_fdiv == FD - 1) begin
                    m_fdiv = 0;
                    for (int i = 0; i < NCH; i++) begin
                        if (m_act[i] < m_tgt[i]) m_act[i] = m_act[i] + 1;
                        else if (m_act[i] > m_tgt[i]) m_act[i] = m_act[i] - 1;
                    end
                end else begin
                    m_fdiv = m_fdiv + 1;
                end
            end
            if (load) begin
                for (int i = 0; i < NCH; i++) begin
                    int lv;
                    lv = int'(level[i*DW +: DW]);
                    m_tgt[i] = (lv > P) ? P : lv;
                end
            end
            m_cnt = (m_tick == 1) ? 0 : m_cnt + 1;
            m_busy = 0;
            for (int i = 0; i < NCH; i++) if (m_act[i] != m_tgt[i]) m_busy = 1;
        end
        #1;
        for (int i = 0; i < NCH; i++) exp_led[i*LW +: LW] = {LW{m_led[i][0]}};
        check("led_out", 32'(led_out), 32'(exp_led));
        check("period_tick", 32'(period_tick), 32'(m_tick));
        check("busy", 32'(busy), 32'(m_busy));
        if (rstn) begin
            for (int i = 0; i < NCH; i++) if (led_out[i*LW]) hi_cnt[i]++;
            if (m_tick == 1) begin
                for (int i = 0; i < NCH; i++) begin
                    if (pc_valid == 1) check("period_high", 32'(hi_cnt[i]), 32'(per_act[i]));
                    hi_cnt[i] = 0;
                    per_act[i] = m_act[i];
                end
                pc_valid = 1;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cnt(input int v);
        int k = 0;
        while (m_cnt != v && k < 3 * P) begin
            @(negedge clk);
            k++;
        end
        if (m_cnt != v) check("wait_cnt_timeout", 32'(m_cnt), 32'(v));
    endtask

    task automatic do_load(input int r, input int g, input int b);
        level = {7'(b), 7'(g), 7'(r)};
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rstn = 1'b0;
        cycles(n);
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0; load = 1'b0; fade_en = 1'b0; level = '0;
        // 1: reset baseline, idle for two periods
        cycles(3);
        rstn = 1'b1;
        cycles(2 * P + 5);
        check("idle_busy", 32'(busy), 32'd0);

        // 2: immediate update mid-period
        wait_cnt(10);
        do_load(33, 66, 100);
        check("busy_after_load", 32'(busy), 32'd1);
        cycles(3 * P);

        // 3: clamp to PERIOD, then off
        wait_cnt(40);
        do_load(127, 0, 127);
        cycles(2 * P);
        wait_cnt(40);
        do_load(0, 127, 0);
        cycles(2 * P);

        // 4: fade 0 -> 5 every second boundary
        do_reset(2);
        fade_en = 1'b1;
        wait_cnt(20);
        do_load(5, 3, 0);
        cycles(12 * P);
        check("fade_done_busy", 32'(busy), 32'd0);

        // 5: LOAD exactly on the boundary cycle
        fade_en = 1'b0;
        wait_cnt(30);
        do_load(20, 20, 20);
        cycles(2 * P);
        wait_cnt(P - 1);
        do_load(40, 40, 40);
        cycles(3 * P);

        // 6: reset in the middle of a ramp
        do_reset(1);
        fade_en = 1'b1;
        wait_cnt(5);
        do_load(60, 30, 90);
        cycles(4 * P);
        wait_cnt(50);
        do_reset(1);
        cycles(4 * P);
        check("no_resume_busy", 32'(busy), 32'd0);

        // Random traffic: loads, fade toggles and occasional resets
        for (int c = 0; c < 6000; c++) begin
            rstn = ($urandom_range(0, 999) != 0);
            if ($urandom_range(0, 199) == 0) fade_en = ~fade_en;
            load = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < NCH; i++) level[i*DW +: DW] = 7'($urandom_range(0, 127));
            @(negedge clk);
        end
        load = 1'b0;
        rstn = 1'b1;
        cycles(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
